// File: rtl/lsu_mem_port.sv
// Load/store initiator for the read-write port (port 2) of the byte-addressed data RAM.
// Takes one request at a time from the core, performs a single-cycle RAM access,
// and returns sign/zero-extended load data or an error flag.
// Optional feature macro: MISALIGN_TRAP_EN. When defined, misaligned half/word
// accesses are flagged as errors; otherwise they complete on the byte-granular RAM.
//
// state  | meaning
// IDLE   | ready for a new request
// ACCESS | drive RAM address; write pulse for stores, sample read data for loads
// RESP   | hold response until the core takes it
module lsu_mem_port #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_wen,
    input  logic [31:0] mem_rdata,
    output logic [31:0] n_loads,
    output logic [31:0] n_stores
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_n_loads;
    logic [31:0] r_n_stores;

    logic [32:0] w_size;
    logic [32:0] w_end;
    logic        w_illegal;
    logic        w_oob;
    logic        w_misalign;
    logic        w_req_err;
    logic [3:0]  w_mask;
    logic [31:0] w_lane_bits;
    logic [31:0] w_load_ext;

    // Classify the incoming request: legal funct3, range (no wrap), alignment.
    always_comb begin
        w_size = 33'd4;
        case (req_funct3[1:0])
            2'b00:   w_size = 33'd1;
            2'b01:   w_size = 33'd2;
            default: w_size = 33'd4;
        endcase
        if (req_store)
            w_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        else
            w_illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
        w_end     = {1'b0, req_addr} + w_size;
        w_oob     = w_end > 33'(MEM_BYTES);
        w_req_err = w_illegal | w_oob | w_misalign;
    end

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                        ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Byte mask and load extension for the latched request.
    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
        w_lane_bits = {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};
        case (r_funct3)
            3'b000:  w_load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            3'b001:  w_load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'b010:  w_load_ext = mem_rdata;
            3'b100:  w_load_ext = {24'h0, mem_rdata[7:0]};
            3'b101:  w_load_ext = {16'h0, mem_rdata[15:0]};
            default: w_load_ext = 32'h0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and RAM-side strobes; the write is gated by rst so a reset mid-access drops it.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mem_wen     = 1'b0;
        mem_wmask   = 4'b0000;
        mem_wdata   = 32'h0;
        case (r_state)
            S_IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                w_state_nxt = S_RESP;
                if (r_store && !r_err && !rst) begin
                    mem_wen   = 1'b1;
                    mem_wmask = w_mask;
                    mem_wdata = r_wdata & w_lane_bits;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture, load data capture and saturating completion counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_store    <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
            r_n_loads  <= 32'h0;
            r_n_stores <= 32'h0;
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_store  <= req_store;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_err    <= w_req_err;
            end
            if (r_state == S_ACCESS)
                r_rdata <= (!r_store && !r_err) ? w_load_ext : 32'h0;
            if (r_state == S_RESP && rsp_ready && !r_err) begin
                if (r_store) begin
                    if (r_n_stores != 32'hFFFF_FFFF) r_n_stores <= r_n_stores + 32'd1;
                end else begin
                    if (r_n_loads != 32'hFFFF_FFFF) r_n_loads <= r_n_loads + 32'd1;
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign n_loads   = r_n_loads;
    assign n_stores  = r_n_stores;

endmodule
